// File: rtl/gpr_wport_scoreboard.sv
// GPR write-port owner and MDU hazard scoreboard.
// The single GPR write port is shared between pipeline writeback and an
// out-of-band MDU result stream. One MDU result can be buffered. Destinations
// with an outstanding MDU write are tracked so that issue stalls on RAW/WAW.
module gpr_wport_scoreboard #(
  parameter int DW       = 32,
  parameter int MAX_WAIT = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          iss_valid,
  input  logic [4:0]    iss_rs,
  input  logic          iss_rs_use,
  input  logic [4:0]    iss_rt,
  input  logic          iss_rt_use,
  input  logic [4:0]    iss_wa,
  input  logic          iss_we,
  input  logic          iss_long,
  output logic          iss_stall,
  input  logic          wb_we,
  input  logic [4:0]    wb_wa,
  input  logic [DW-1:0] wb_wd,
  output logic          wb_hold,
  input  logic          mdu_valid,
  output logic          mdu_ready,
  input  logic [4:0]    mdu_wa,
  input  logic [DW-1:0] mdu_wd,
  output logic          gpr_we,
  output logic [4:0]    gpr_wa,
  output logic [DW-1:0] gpr_wd,
  output logic [5:0]    pend_cnt
);

  localparam logic [3:0] W_MAX = 4'(MAX_WAIT);

  typedef enum logic [1:0] {SRC_NONE, SRC_WB, SRC_BUF, SRC_MDU} src_e;

  logic [31:0]   r_pend;
  logic [5:0]    r_pend_cnt;
  logic          r_buf_valid;
  logic [4:0]    r_buf_wa;
  logic [DW-1:0] r_buf_wd;
  logic [3:0]    r_wait_cnt;

  src_e          w_src;
  logic          w_starve;
  logic          w_buf_grant;
  logic          w_mdu_acc;
  logic          w_fire;
  logic          w_hazard;
  logic [31:0]   w_set_mask;
  logic [31:0]   w_clr_mask;
  logic [31:0]   w_pend_nxt;
  logic [5:0]    w_pend_cnt_nxt;

  // Hazard check against registered pending bits only; reset holds issue.
  always_comb begin
    w_hazard = (iss_rs_use && (iss_rs != 5'd0) && r_pend[iss_rs])
             | (iss_rt_use && (iss_rt != 5'd0) && r_pend[iss_rt])
             | (iss_we     && (iss_wa != 5'd0) && r_pend[iss_wa]);
    iss_stall = reset | (iss_valid & w_hazard);
    w_fire    = iss_valid & ~iss_stall;
  end

  // Write-port arbitration: starving buffer, then WB, then buffer, then direct MDU.
  always_comb begin
    w_starve = r_buf_valid & (r_wait_cnt >= W_MAX);
    w_src    = SRC_NONE;
    if (reset)            w_src = SRC_NONE;
    else if (w_starve)    w_src = SRC_BUF;
    else if (wb_we)       w_src = SRC_WB;
    else if (r_buf_valid) w_src = SRC_BUF;
    else if (mdu_valid)   w_src = SRC_MDU;
    w_buf_grant = (w_src == SRC_BUF);
    mdu_ready   = ~reset & (~r_buf_valid | w_buf_grant);
    w_mdu_acc   = mdu_valid & mdu_ready;
    wb_hold     = ~reset & w_starve & wb_we;
  end

  // Port data mux; writes to reg 0 are consumed without enabling the GPR.
  always_comb begin
    gpr_wa = 5'd0;
    gpr_wd = '0;
    case (w_src)
      SRC_WB:  begin gpr_wa = wb_wa;    gpr_wd = wb_wd;    end
      SRC_BUF: begin gpr_wa = r_buf_wa; gpr_wd = r_buf_wd; end
      SRC_MDU: begin gpr_wa = mdu_wa;   gpr_wd = mdu_wd;   end
      default: ;
    endcase
    gpr_we = (w_src != SRC_NONE) && (gpr_wa != 5'd0);
  end

  // Next pending set: MDU/buffer commits clear, long-latency issues set.
  always_comb begin
    w_set_mask = '0;
    w_clr_mask = '0;
    if (w_fire && iss_we && iss_long && (iss_wa != 5'd0))
      w_set_mask[iss_wa] = 1'b1;
    if (((w_src == SRC_BUF) || (w_src == SRC_MDU)) && (gpr_wa != 5'd0))
      w_clr_mask[gpr_wa] = 1'b1;
    w_pend_nxt    = (r_pend & ~w_clr_mask) | w_set_mask;
    w_pend_nxt[0] = 1'b0;
    w_pend_cnt_nxt = 6'd0;
    for (int i = 0; i < 32; i++)
      w_pend_cnt_nxt = w_pend_cnt_nxt + 6'(w_pend_nxt[i]);
  end

  // Scoreboard, MDU buffer and starvation counter state.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pend      <= '0;
      r_pend_cnt  <= 6'd0;
      r_buf_valid <= 1'b0;
      r_buf_wa    <= 5'd0;
      r_buf_wd    <= '0;
      r_wait_cnt  <= 4'd0;
    end else begin
      r_pend     <= w_pend_nxt;
      r_pend_cnt <= w_pend_cnt_nxt;
      // A new accept that did not go straight to the port takes the slot,
      // even when the old entry leaves in the same cycle.
      if (w_mdu_acc && (w_src != SRC_MDU)) begin
        r_buf_valid <= 1'b1;
        r_buf_wa    <= mdu_wa;
        r_buf_wd    <= mdu_wd;
      end else if (w_buf_grant) begin
        r_buf_valid <= 1'b0;
      end
      if (!r_buf_valid || w_buf_grant) r_wait_cnt <= 4'd0;
      else if (r_wait_cnt != 4'd15)    r_wait_cnt <= r_wait_cnt + 4'd1;
    end
  end

  assign pend_cnt = r_pend_cnt;

endmodule
